lsu_mem: RTL and testbench

Load/store unit for the MEM stage of the RV32 pipeline, between the EX/MEM register and `mem_wb`. Turns a load or store from EX/MEM into a request on the data-memory handshake bus, with byte enables and lane-shifted write data. It stalls the pipeline while the access is outstanding. Load data is sign- or zero-extended and presented on `mem_rd_data_out`, which feeds `mem_wb.mem_rd_data_in`.

---
 rtl/lsu_mem.sv | 153 +++++++++++++++
 tb/tb_lsu_mem.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem.sv
// MEM-stage load/store unit: issues data-memory requests, stalls the pipeline until done, formats load data.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_EXC_EN.
module lsu_mem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd_en_in,
  input  logic        mem_wr_en_in,
  input  logic [2:0]  mem_funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wr_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_rd_data_out,
  output logic        lsu_stall,
  output logic [1:0]  dbg_state_o
`ifdef LSU_MISALIGN_EXC_EN
  ,
  output logic        misalign_exc_out
`endif
);

  // Handshake: a request transfers on a cycle with dmem_req && dmem_gnt; read data returns
  // later on a cycle with dmem_rvalid, one response per granted load, no backpressure on it.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        access;
  logic        is_store;
  logic        misaligned;
  logic        req;
  logic        done;
  logic        capture;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  assign access   = mem_rd_en_in | mem_wr_en_in;
  assign is_store = mem_wr_en_in;

`ifdef LSU_MISALIGN_EXC_EN
  assign misaligned = ((mem_funct3_in[1:0] == 2'b01) & addr_in[0]) |
                      ((mem_funct3_in == 3'b010) & (addr_in[1:0] != 2'b00));
  assign misalign_exc_out = rst_n & access & misaligned;
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    be    = 4'b1111;
    wdata = wr_data_in;
    case (mem_funct3_in[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_in[1:0];
        wdata = {4{wr_data_in[7:0]}};
      end
      2'b01: begin
        be    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wr_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (addr_in[1:0])
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      2'd3:    ld_byte = dmem_rdata[31:24];
      default: ;
    endcase
    ld_half = addr_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (mem_funct3_in)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    done    = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !misaligned) begin
          req = 1'b1;
          if (dmem_gnt) begin
            if (is_store) done = 1'b1;
            else          state_d = WAIT_RSP;
          end else begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (dmem_gnt) begin
          done    = is_store;
          state_d = is_store ? IDLE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid) begin
          done    = 1'b1;
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_data_d = capture ? ld_fmt : rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Bus outputs are forced quiet while reset is asserted, even if upstream presents an access.
  assign dmem_req        = rst_n & req;
  assign dmem_we         = dmem_req & is_store;
  assign dmem_addr       = dmem_req ? {addr_in[31:2], 2'b00} : 32'd0;
  assign dmem_be         = dmem_req ? be : 4'd0;
  assign dmem_wdata      = (dmem_req && is_store) ? wdata : 32'd0;
  assign lsu_stall       = rst_n & access & ~misaligned & ~done;
  assign mem_rd_data_out = capture ? ld_fmt : rd_data_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Randomized bench for lsu_mem against a byte-lane reference model and a load-result queue.
module tb_lsu_mem;

  logic        clk;
  logic        rst_n;
  logic        mem_rd_en_in;
  logic        mem_wr_en_in;
  logic [2:0]  mem_funct3_in;
  logic [31:0] addr_in;
  logic [31:0] wr_data_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_rd_data_out;
  logic        lsu_stall;
  logic [1:0]  dbg_state_o;
`ifdef LSU_MISALIGN_EXC_EN
  logic        misalign_exc_out;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_load = 32'd0;
  logic [31:0] exp_q[$];

  lsu_mem dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_rd_en_in    (mem_rd_en_in),
    .mem_wr_en_in    (mem_wr_en_in),
    .mem_funct3_in   (mem_funct3_in),
    .addr_in         (addr_in),
    .wr_data_in      (wr_data_in),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .mem_rd_data_out (mem_rd_data_out),
    .lsu_stall       (lsu_stall),
    .dbg_state_o     (dbg_state_o)
`ifdef LSU_MISALIGN_EXC_EN
    ,
    .misalign_exc_out(misalign_exc_out)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sizes and lanes as plain arithmetic
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int lane_of(input logic [2:0] f3, input logic [31:0] a);
    int nb;
    nb = nbytes(f3);
    return (int'(a[1:0]) / nb) * nb;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int nb;
    nb = nbytes(f3);
    return 4'(((1 << nb) - 1) << lane_of(f3, a));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int nb;
    nb = nbytes(f3);
    w = 32'd0;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = d[(k % nb)*8 +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v, mask;
    int nb;
    nb = nbytes(f3);
    v  = rd >> (8 * lane_of(f3, a));
    if (nb < 4) begin
      mask = (32'd1 << (8 * nb)) - 32'd1;
      v    = v & mask;
      if (!f3[2] && v[8*nb - 1]) v = v | ~mask;
    end
    return v;
  endfunction

`ifdef LSU_MISALIGN_EXC_EN
  function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (nbytes(f3) == 2 && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver: one complete access with given grant and response delays.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int gd, input int rd,
                           input logic [31:0] rsp);
    int          last;
    logic        rv;
    logic [31:0] e;
    last = we ? gd : gd + 1 + rd;
    if (!we) exp_q.push_back(ref_load(f3, a, rsp));
    mem_wr_en_in  = we;
    mem_rd_en_in  = we ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_funct3_in = f3;
    addr_in       = a;
    wr_data_in    = wd;
    for (int i = 0; i <= last; i++) begin
      rv          = (!we && i == last) ? 1'b1 : ((i <= gd) ? 1'($urandom_range(0, 1)) : 1'b0);
      dmem_gnt    = (i == gd);
      dmem_rvalid = rv;
      dmem_rdata  = (!we && i == last) ? rsp : $urandom;
      @(negedge clk);
      check("req", 32'(dmem_req), 32'(i <= gd));
      if (i <= gd) begin
        check("we", 32'(dmem_we), 32'(we));
        check("addr", dmem_addr, {a[31:2], 2'b00});
        check("be", 32'(dmem_be), 32'(ref_be(f3, a)));
        if (we) check("wdata", dmem_wdata, ref_wdata(f3, wd));
      end
      check("stall", 32'(lsu_stall), 32'(we ? (i < gd) : (i != last)));
      if (!we && i == last) begin
        e         = exp_q.pop_front();
        last_load = e;
        check("ld_data", mem_rd_data_out, e);
      end else begin
        check("ld_hold", mem_rd_data_out, last_load);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycle();
    mem_rd_en_in = 1'b0;
    mem_wr_en_in = 1'b0;
    addr_in      = $urandom;
    dmem_gnt     = 1'($urandom_range(0, 1));
    dmem_rvalid  = 1'($urandom_range(0, 1));
    dmem_rdata   = $urandom;
    @(negedge clk);
    check("idle_req", 32'(dmem_req), 32'd0);
    check("idle_stall", 32'(lsu_stall), 32'd0);
    check("idle_hold", mem_rd_data_out, last_load);
    @(posedge clk); #1;
  endtask

`ifdef LSU_MISALIGN_EXC_EN
  task automatic misaligned_access(input logic we, input logic [2:0] f3, input logic [31:0] a);
    mem_wr_en_in  = we;
    mem_rd_en_in  = ~we;
    mem_funct3_in = f3;
    addr_in       = a;
    wr_data_in    = $urandom;
    dmem_gnt      = 1'($urandom_range(0, 1));
    dmem_rvalid   = 1'b0;
    dmem_rdata    = $urandom;
    @(negedge clk);
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_exc", 32'(misalign_exc_out), 32'd1);
    check("mis_stall", 32'(lsu_stall), 32'd0);
    check("mis_hold", mem_rd_data_out, last_load);
    @(posedge clk); #1;
  endtask
`endif

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(dbg_state_o), 32'd0);  // IDLE encodes as 0
    check({tag, "_req"}, 32'(dmem_req), 32'd0);
    check({tag, "_we"}, 32'(dmem_we), 32'd0);
    check({tag, "_addr"}, dmem_addr, 32'd0);
    check({tag, "_be"}, 32'(dmem_be), 32'd0);
    check({tag, "_wdata"}, dmem_wdata, 32'd0);
    check({tag, "_stall"}, 32'(lsu_stall), 32'd0);
    check({tag, "_rdout"}, mem_rd_data_out, 32'd0);
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;

    // Reset with an access presented: every output must stay quiet.
    rst_n         = 1'b0;
    mem_rd_en_in  = 1'b0;
    mem_wr_en_in  = 1'b1;
    mem_funct3_in = 3'b010;
    addr_in       = 32'h1234_5677;
    wr_data_in    = 32'hDEAD_BEEF;
    dmem_gnt      = 1'b1;
    dmem_rvalid   = 1'b1;
    dmem_rdata    = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycle();

    // Directed cases
    do_access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'd0);
    do_access(1'b0, 3'b000, 32'h0000_2001, 32'd0, 0, 1, 32'h1234_8056);
    do_access(1'b0, 3'b100, 32'h0000_2001, 32'd0, 0, 1, 32'h1234_8056);
    do_access(1'b0, 3'b001, 32'h0000_2002, 32'd0, 0, 0, 32'h8000_1234);
    do_access(1'b1, 3'b010, 32'h0000_3000, 32'h0BAD_F00D, 3, 0, 32'd0);
`ifdef LSU_MISALIGN_EXC_EN
    misaligned_access(1'b0, 3'b010, 32'h0000_4002);
`else
    do_access(1'b0, 3'b010, 32'h0000_4002, 32'd0, 0, 0, 32'hCAFE_0001);
`endif
    idle_cycle();

    // Randomized traffic, including back-to-back accesses
    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
`ifdef LSU_MISALIGN_EXC_EN
      if (ref_misaligned(f3, a)) misaligned_access(we, f3, a);
      else
`endif
      do_access(we, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    // Make sure rd_data_q holds something non-zero before the mid-access reset.
    do_access(1'b0, 3'b010, 32'h0000_5000, 32'd0, 0, 0, 32'h8765_4321);

    // Reset while waiting for a load response.
    mem_wr_en_in  = 1'b0;
    mem_rd_en_in  = 1'b1;
    mem_funct3_in = 3'b010;
    addr_in       = 32'h0000_6000;
    dmem_gnt      = 1'b1;
    dmem_rvalid   = 1'b0;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    check("pre_rst_stall", 32'(lsu_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    mem_rd_en_in = 1'b0;
    rst_n        = 1'b1;
    last_load    = 32'd0;
    idle_cycle();
    do_access(1'b0, 3'b101, 32'h0000_7002, 32'd0, 1, 2, 32'hF00F_1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
